// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: state encodings and bus widths shared by the arbiter
package bus_arbiter_pkg;
  localparam logic [1:0] BUS_ARB_IDLE = 2'd0;
  localparam logic [1:0] BUS_ARB_GNT_IF = 2'd1;
  localparam logic [1:0] BUS_ARB_GNT_D = 2'd2;
  localparam int DATA_W = 32;
  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] SEL_ALL = '1;
endpackage

// File: rtl/bus_arbiter.sv
// bus_arbiter: fetch/data to single-slave arbiter with data-first alternation and ack watchdog
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [DATA_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              d_ce_i,
  input  logic              d_we_i,
  input  logic [DATA_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [SEL_W-1:0]  d_sel_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              err_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [SEL_W-1:0]  mem_sel_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);
  logic [1:0] state;
  logic last_d, we_q;
  logic [7:0] cnt;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata;
  logic [SEL_W-1:0] sel_q;
  logic want_if, want_d, pick_d, tmo, done;
  // a master still holds ce during its own ack cycle; do not re-grant it then
  assign want_if = if_ce_i & ~if_ack_o;
  assign want_d = d_ce_i & ~d_ack_o;
  assign pick_d = want_d & (~want_if | ~last_d);
  assign tmo = cnt == 8'(TIMEOUT - 1);
  assign done = mem_ack_i | tmo;
  assign rdata = mem_ack_i ? mem_rdata_i : '0;
  assign mem_ce_o = state != BUS_ARB_IDLE;
  assign mem_we_o = we_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_sel_o = sel_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BUS_ARB_IDLE;
      last_d <= 1'b0;
      cnt <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      sel_q <= '0;
      if_data_o <= '0;
      d_rdata_o <= '0;
      if_ack_o <= 1'b0;
      d_ack_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      if_ack_o <= 1'b0;
      d_ack_o <= 1'b0;
      err_o <= 1'b0;
      if (state == BUS_ARB_IDLE) begin
        if (want_if | want_d) begin
          state <= pick_d ? BUS_ARB_GNT_D : BUS_ARB_GNT_IF;
          addr_q <= pick_d ? d_addr_i : if_addr_i;
          we_q <= pick_d & d_we_i;
          wdata_q <= pick_d ? d_wdata_i : '0;
          sel_q <= pick_d ? d_sel_i : SEL_ALL;
          cnt <= '0;
        end
      end else if (done) begin
        state <= BUS_ARB_IDLE;
        err_o <= ~mem_ack_i;
        last_d <= state == BUS_ARB_GNT_D;
        if (state == BUS_ARB_GNT_D) begin
          d_ack_o <= 1'b1;
          d_rdata_o <= we_q ? '0 : rdata;
        end else begin
          if_ack_o <= 1'b1;
          if_data_o <= rdata;
        end
      end else
        cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table, corner sequences and randomized traffic against a memory model
module tb_bus_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst;
  logic if_ce_i, if_ack_o, d_ce_i, d_we_i, d_ack_o, err_o;
  logic mem_ce_o, mem_we_o, mem_ack_i;
  logic [31:0] if_addr_i, if_data_o, d_addr_i, d_wdata_i, d_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0] d_sel_i, mem_sel_o;
  always #5 clk = ~clk;
  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .d_ce_i(d_ce_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_sel_i(d_sel_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o), .err_o(err_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i)
  );
  typedef struct {
    bit is_d; bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] sel;
    int lat; logic [31:0] rd; int exp_ack; logic [31:0] exp_data; bit exp_err;
    bit exp_we; logic [3:0] exp_sel;
  } vec_t;
  vec_t tv[7];
  int checks = 0, errors = 0;
  int s_cnt = 0, s_lat = 0, fix_lat = 1;
  bit rand_mode = 0, inj = 0;
  logic [31:0] fix_rd = '0;
  logic [31:0] smem[16], rmem[16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // slave: picks a latency when ce rises, acks only while ce is still high
  task automatic slave_update();
    logic ack;
    if (mem_ce_o) begin
      if (s_cnt == 0) s_lat = rand_mode ? int'($urandom_range(1, 7)) : fix_lat;
      s_cnt++;
    end else s_cnt = 0;
    ack = mem_ce_o && s_lat > 0 && s_cnt == s_lat + 1;
    mem_rdata_i = $urandom;
    if (ack && !mem_we_o) mem_rdata_i = rand_mode ? smem[mem_addr_o[5:2]] : fix_rd;
    if (ack && mem_we_o)
      for (int b = 0; b < 4; b++)
        if (mem_sel_o[b]) smem[mem_addr_o[5:2]][8*b+:8] = mem_wdata_o[8*b+:8];
    mem_ack_i = ack | inj;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    slave_update();
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_data"}, if_data_o | d_rdata_o, 0);
    chk({tag, "_bus"}, mem_addr_o | mem_wdata_o, 0);
    chk({tag, "_ctl"}, {if_ack_o, d_ack_o, err_o, mem_ce_o, mem_we_o, mem_sel_o}, 0);
  endtask
  task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input int lat, input logic [31:0] rd,
                         output int t_ce, output int t_ack, output logic [31:0] data, output bit err,
                         output logic [31:0] m_addr, output logic [31:0] m_wdata, output bit m_we,
                         output logic [3:0] m_sel);
    fix_lat = lat; fix_rd = rd; t_ce = -1; t_ack = -1; data = '0; err = 0;
    m_addr = '0; m_wdata = '0; m_we = 0; m_sel = '0;
    if_ce_i = !is_d; if_addr_i = addr;
    d_ce_i = is_d; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata; d_sel_i = sel;
    for (int i = 1; i <= 30 && t_ack < 0; i++) begin
      tick();
      if (mem_ce_o && t_ce < 0) begin
        t_ce = i; m_addr = mem_addr_o; m_wdata = mem_wdata_o; m_we = mem_we_o; m_sel = mem_sel_o;
      end
      if (if_ack_o || d_ack_o) begin
        t_ack = i; data = is_d ? d_rdata_o : if_data_o; err = err_o;
      end
    end
    tick();
    if_ce_i = 0; d_ce_i = 0;
  endtask
  initial begin
    int t_ce, t_ack, n, bad, zc, done, cyc;
    bit err, m_we, seen, ip, dp, dwe, exp_err;
    logic [31:0] data, m_addr, m_wdata, ia, da, dwd, exp_d;
    logic [3:0] m_sel, ds;
    int order[$], gaps[$];
    int iw, dw, iage, dage;
    tv[0] = '{0, 0, 32'h4,   32'h0,        4'h5, 1, 32'h34011100, 3, 32'h34011100, 0, 0, 4'hf};
    tv[1] = '{1, 1, 32'h100, 32'hDEADBEEF, 4'h3, 2, 32'hFFFFFFFF, 4, 32'h0,        0, 1, 4'h3};
    tv[2] = '{1, 0, 32'h200, 32'h11111111, 4'hf, 3, 32'h12345678, 5, 32'h12345678, 0, 0, 4'hf};
    tv[3] = '{1, 0, 32'h300, 32'h0,        4'h6, 0, 32'h0,        5, 32'h0,        1, 0, 4'h6};
    tv[4] = '{0, 0, 32'h40,  32'h0,        4'h0, 4, 32'hAAAA5555, 5, 32'h0,        1, 0, 4'hf};
    tv[5] = '{0, 0, 32'h44,  32'h0,        4'h0, 3, 32'hCAFEF00D, 5, 32'hCAFEF00D, 0, 0, 4'hf};
    tv[6] = '{1, 1, 32'h48,  32'h87654321, 4'hc, 7, 32'h0,        5, 32'h0,        1, 1, 4'hc};
    rst = 1; if_ce_i = 0; d_ce_i = 0; d_we_i = 0; if_addr_i = '0; d_addr_i = '0;
    d_wdata_i = '0; d_sel_i = '0; mem_ack_i = 0; mem_rdata_i = '0;
    repeat (3) tick();
    check_zero("reset");
    rst = 0;
    // contention straight out of reset: D, IF, D, IF with one idle cycle between grants
    if_ce_i = 1; d_ce_i = 1; d_we_i = 0; if_addr_i = 32'h10; d_addr_i = 32'h20; d_sel_i = 4'hf;
    fix_lat = 1; fix_rd = 32'h55; zc = 0; seen = 0;
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      tick();
      if (d_ack_o) order.push_back(1);
      if (if_ack_o) order.push_back(0);
      if (mem_ce_o) begin
        if (seen && zc > 0) gaps.push_back(zc);
        seen = 1; zc = 0;
      end else if (seen) zc++;
    end
    if_ce_i = 0; d_ce_i = 0;
    chk("contention_acks", order.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("grant_%0d_is_d", k), k < order.size() ? order[k] : 2, k % 2 == 0);
    chk("contention_gaps", gaps.size(), 3);
    for (int k = 0; k < gaps.size(); k++) chk($sformatf("idle_gap_%0d", k), gaps[k], 1);
    tick(); tick();
    for (int k = 0; k < 7; k++) begin
      run_txn(tv[k].is_d, tv[k].we, tv[k].addr, tv[k].wdata, tv[k].sel, tv[k].lat, tv[k].rd,
              t_ce, t_ack, data, err, m_addr, m_wdata, m_we, m_sel);
      chk($sformatf("v%0d_ce_cycle", k), t_ce, 1);
      chk($sformatf("v%0d_ack_cycle", k), t_ack, tv[k].exp_ack);
      chk($sformatf("v%0d_data", k), data, tv[k].exp_data);
      chk($sformatf("v%0d_err", k), err, tv[k].exp_err);
      chk($sformatf("v%0d_mem_we", k), m_we, tv[k].exp_we);
      chk($sformatf("v%0d_mem_sel", k), m_sel, tv[k].exp_sel);
      chk($sformatf("v%0d_mem_addr", k), m_addr, tv[k].addr);
      if (tv[k].we) chk($sformatf("v%0d_mem_wdata", k), m_wdata, tv[k].wdata);
    end
    chk("d_rdata_hold", d_rdata_o, 32'h0);
    chk("if_data_hold", if_data_o, 32'hCAFEF00D);
    // watchdog abort followed by a stray late ack
    fix_lat = 0; d_ce_i = 1; d_we_i = 0; d_addr_i = 32'h300; d_sel_i = 4'hf; n = -1;
    for (int i = 1; i <= 20 && n < 0; i++) begin
      tick();
      if (d_ack_o) begin
        n = i;
        chk("tmo_err", err_o, 1);
        chk("tmo_rdata", d_rdata_o, 0);
      end
    end
    chk("tmo_latency", n, 5);
    inj = 1;
    tick();
    inj = 0; d_ce_i = 0; bad = 0;
    repeat (4) begin
      tick();
      bad += (d_ack_o | if_ack_o | err_o | mem_ce_o | (d_rdata_o != 0)) ? 1 : 0;
    end
    chk("late_ack_ignored", bad, 0);
    // reset in the second cycle of a 5-cycle slave access
    fix_lat = 5; if_ce_i = 1; if_addr_i = 32'h80;
    tick(); tick();
    chk("mid_ce_high", mem_ce_o, 1);
    rst = 1; if_ce_i = 0;
    tick();
    rst = 0;
    check_zero("mid_rst");
    bad = 0;
    repeat (8) begin
      tick();
      bad += (if_ack_o | d_ack_o | err_o | mem_ce_o) ? 1 : 0;
    end
    chk("mid_rst_no_ack", bad, 0);
    run_txn(0, 0, 32'h84, 32'h0, 4'h0, 1, 32'h600DF00D, t_ce, t_ack, data, err, m_addr, m_wdata, m_we, m_sel);
    chk("post_rst_ack_cycle", t_ack, 3);
    chk("post_rst_data", data, 32'h600DF00D);
    chk("post_rst_err", err, 0);
    // randomized mixed traffic against a reference memory
    rand_mode = 1;
    for (int k = 0; k < 16; k++) begin
      smem[k] = $urandom; rmem[k] = smem[k];
    end
    ip = 0; dp = 0; done = 0; cyc = 0; iw = 0; dw = 0; iage = 0; dage = 0;
    ia = '0; da = '0; dwd = '0; ds = '0; dwe = 0;
    while (done < 200 && cyc < 20000) begin
      tick();
      cyc++;
      exp_err = s_lat >= TO;
      if (if_ack_o && d_ack_o) begin
        checks++; errors++; $display("FAIL rnd_dual_ack: got both acks expected one");
      end
      if (err_o && !if_ack_o && !d_ack_o) begin
        checks++; errors++; $display("FAIL rnd_err_alone: got err_o=1 expected 0 without ack");
      end
      if (if_ack_o) begin
        if (!ip) begin
          checks++; errors++; $display("FAIL rnd_if_spurious: got ack expected none");
        end else begin
          chk("rnd_if_err", err_o, exp_err);
          chk("rnd_if_data", if_data_o, exp_err ? 32'h0 : rmem[ia[5:2]]);
          chk("rnd_if_wait", iw <= 1, 1);
          ip = 0; done++;
        end
        if (dp) dw++;
      end
      if (d_ack_o) begin
        if (!dp) begin
          checks++; errors++; $display("FAIL rnd_d_spurious: got ack expected none");
        end else begin
          exp_d = (exp_err || dwe) ? 32'h0 : rmem[da[5:2]];
          chk("rnd_d_err", err_o, exp_err);
          chk("rnd_d_data", d_rdata_o, exp_d);
          chk("rnd_d_wait", dw <= 1, 1);
          if (dwe && !exp_err)
            for (int b = 0; b < 4; b++) if (ds[b]) rmem[da[5:2]][8*b+:8] = dwd[8*b+:8];
          dp = 0; done++;
        end
        if (ip) iw++;
      end
      if (ip && ++iage > 100) begin
        checks++; errors++; $display("FAIL rnd_if_starved: got no ack after %0d cycles", iage); ip = 0;
      end
      if (dp && ++dage > 100) begin
        checks++; errors++; $display("FAIL rnd_d_starved: got no ack after %0d cycles", dage); dp = 0;
      end
      if (!ip) begin
        if_ce_i = $urandom_range(0, 2) == 0;
        if (if_ce_i) begin
          ip = 1; iw = 0; iage = 0; ia = 32'h1000 | ($urandom_range(0, 15) << 2); if_addr_i = ia;
        end
      end
      if (!dp) begin
        d_ce_i = $urandom_range(0, 2) == 0;
        if (d_ce_i) begin
          dp = 1; dw = 0; dage = 0; da = 32'h2000 | ($urandom_range(0, 15) << 2);
          dwe = $urandom_range(0, 1) == 1; dwd = $urandom; ds = 4'($urandom_range(1, 15));
          d_addr_i = da; d_we_i = dwe; d_wdata_i = dwd; d_sel_i = ds;
        end
      end
    end
    chk("rnd_completed", done >= 200, 1);
    if_ce_i = 0; d_ce_i = 0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter between the CPU core and the SOPC memory port. The masters are the instruction-fetch port and the load/store data port; the slave is a single-port, variable-latency memory. The block sits in min_sopc between top and the memory, and will replace the direct top↔rom wiring once instruction and data storage are unified. It serialises accesses with a req/ack handshake, uses data-first priority with alternation under contention, and applies a watchdog timeout so a missing slave ack cannot hang the core.

## Interface
- TIMEOUT, 16: cycles to wait for mem_ack_i before aborting; legal range 2..255.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_ce_i  in  1  fetch request, held until if_ack_o.
- if_addr_i  in  32 (`InstAddrBus`)  fetch address.
- if_data_o  out  32 (`InstBus`)  fetched instruction, valid with if_ack_o.
- if_ack_o  out  1  one-cycle completion pulse.
- d_ce_i  in  1  data request, held until d_ack_o.
- d_we_i  in  1  1 = write, 0 = read.
- d_addr_i  in  32  data address.
- d_wdata_i  in  32  write data.
- d_sel_i  in  4  byte enables.
- d_rdata_o  out  32  read data, valid with d_ack_o.
- d_ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse, coincident with the ack of a timed-out access.
- mem_ce_o, mem_we_o  out  1 each  slave strobe and write enable.
- mem_addr_o, mem_wdata_o  out  32 each  slave address and write data.
- mem_sel_o  out  4  slave byte enables.
- mem_rdata_i  in  32  slave read data.
- mem_ack_i  in  1  slave completion; may arrive 1..N cycles after mem_ce_o rises.

## Operation
- States: IDLE, GNT_IF, GNT_D.
- IDLE, only d_ce_i set: go to GNT_D.
- IDLE, only if_ce_i set: go to GNT_IF.
- IDLE, both set: grant the data port unless last_d = 1; in that case grant fetch.
  - last_d is a 1-bit flag: set on each data completion, cleared on each fetch completion.
  - Under sustained contention, grants therefore alternate D, IF, D, IF.
- On grant: latch the granted master's address, we, wdata and sel into registers.
  - For a fetch: we = 0, sel = 4'b1111.
  - Drive mem_* from these registers.
  - Hold mem_ce_o = 1 for the whole GNT state.
- GNT_*, mem_ack_i = 1:
  - Register mem_rdata_i into the granted master's data output.
  - Pulse that master's ack for one cycle.
  - Deassert mem_ce_o.
  - Return to IDLE.
- Data writes: d_rdata_o = 0 on ack.
- Timeout counter: cleared on grant, increments each GNT cycle without mem_ack_i.
  - When it reaches TIMEOUT-1 with no ack: complete as above with data = 0, err_o = 1, then return to IDLE.
  - A mem_ack_i arriving in IDLE (late ack) is ignored.
- A master dropping its ce while granted is a protocol violation. The transaction still completes; its ack is still issued.
- Data outputs hold their last value between acks.

## Timing
- Reset values: all outputs 0; state IDLE; last_d = 0; counter 0.
- Request sampled in IDLE at edge N: mem_ce_o = 1 from cycle N+1.
- mem_ack_i sampled at edge M: ack and data valid during cycle M+1; state is IDLE in M+1.
- Minimum access: 3 cycles request-to-ack with a 1-cycle slave.
- Every back-to-back transaction has exactly 1 IDLE cycle between grants.
- Timeout: err_o/ack fire in the cycle after the TIMEOUT-th unacked GNT cycle.
- rst asserted mid-transaction: everything returns to reset values next cycle.
  - No ack is issued.
  - mem_ce_o drops immediately after that edge.

## Structure
- defines.v gains:
  - `BusArbIdle`, `BusArbGntIf`, `BusArbGntD`: 2-bit state encodings.
  - `DataBus`: 31:0.
  - `SelBus`: 3:0.
- Reuse the existing `InstAddrBus`/`InstBus`, `RstEnable`, `ChipEnable`/`ChipDisable`.
- Single module; no sub-module.
- Timeout counter is 8 bits, inline.

## Test plan
- Fetch only, slave acks 1 cycle after ce:
  - if_addr_i = 0x0000_0004, mem_rdata_i = 0x3401_1100.
  - Expect mem_ce_o at N+1, if_data_o = 0x3401_1100 with if_ack_o at N+3, err_o = 0.
- Contention from reset (last_d = 0), both ce held high:
  - Grant order D, IF, D, IF.
  - Each ack pulses once, 1 IDLE cycle between grants.
- Data write: d_addr_i = 0x100, d_wdata_i = 0xDEAD_BEEF, sel = 4'b0011.
  - mem_we_o = 1, mem_sel_o = 4'b0011, d_rdata_o = 0 on ack.
- Slave never acks, TIMEOUT = 4:
  - d_ack_o and err_o pulse together 5 cycles after the request is sampled.
  - d_rdata_o = 0.
  - A mem_ack_i injected one cycle later is ignored.
- rst asserted on cycle 2 of a 5-cycle slave access:
  - All outputs 0 next cycle, no ack.
  - A new fetch afterwards completes normally.
- Variable slave latency 1..7 cycles, randomised, 200 mixed transactions:
  - Every request gets exactly one ack.
  - Data matches the memory model.
  - No master waits more than one other master's transaction.
